regfile_fwd: RTL and testbench

- Parametrised general-purpose register file with an integrated operand bypass network and load-use hazard detection.
- Replaces the fixed two-read-port register file plus the ad-hoc EX/MEM forwarding muxes in the decode stage.
- Sits between decode and the pipeline result buses:
  - Decode drives read requests.
  - Any number of downstream stages offer forwarding candidates.
  - Write-back drives the write port.
  - The block returns resolved operands and a stall request for pipeline control.

---
 rtl/regfile_fwd_pkg.sv | 10 +
 rtl/regfile_fwd_port.sv | 60 ++++++
 rtl/regfile_fwd.sv | 82 ++++++++
 tb/tb_regfile_fwd.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_fwd_pkg.sv
// Shared constants for the register file with operand bypass and load-use stall.
// Default port counts, the hard-wired zero register and the stall counter width.
package regfile_fwd_pkg;

    localparam int RegFwdNum   = 2;
    localparam int RegReadNum  = 2;
    localparam int ZeroReg     = 0;
    localparam int StallCntBus = 32;

endpackage

// File: rtl/regfile_fwd_port.sv
// Combinational resolver for one read port: register 0, youngest-first bypass,
// write-through, then storage; raises a stall when the selected source is not ready.
module regfile_fwd_port
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NFWD   = RegFwdNum
) (
    input  logic                     i_re,
    input  logic [ADDR_W-1:0]        i_raddr,
    input  logic [DATA_W-1:0]        i_entry,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [NFWD-1:0]          i_fwd_we,
    input  logic [NFWD*ADDR_W-1:0]   i_fwd_addr,
    input  logic [NFWD*DATA_W-1:0]   i_fwd_data,
    input  logic [NFWD-1:0]          i_fwd_rdy,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_stall
);

    logic              w_hit;
    logic              w_hitRdy;
    logic [DATA_W-1:0] w_fwdData;

    // Scan oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hitRdy  = 1'b0;
        w_fwdData = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (i_fwd_we[k] && (i_fwd_addr[k*ADDR_W +: ADDR_W] == i_raddr)) begin
                w_hit     = 1'b1;
                w_hitRdy  = i_fwd_rdy[k];
                w_fwdData = i_fwd_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        o_stall = 1'b0;
        if (i_re && (i_raddr != ADDR_W'(ZeroReg))) begin
            if (w_hit) begin
                if (w_hitRdy) begin
                    o_rdata = w_fwdData;
                end else begin
                    o_stall = 1'b1;
                end
            end else if (i_we && (i_waddr == i_raddr)) begin
                o_rdata = i_wdata;
            end else begin
                o_rdata = i_entry;
            end
        end
    end

endmodule

// File: rtl/regfile_fwd.sv
// Register file with integrated bypass network: storage, write port, per-port
// resolvers, the combined stall request and a saturating stall-cycle counter.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = RegReadNum,
    parameter int NFWD   = RegFwdNum
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NREAD-1:0]         re,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    input  logic [NFWD-1:0]          fwd_we,
    input  logic [NFWD*ADDR_W-1:0]   fwd_addr,
    input  logic [NFWD*DATA_W-1:0]   fwd_data,
    input  logic [NFWD-1:0]          fwd_rdy,
    output logic                     stall_req,
    output logic [StallCntBus-1:0]   stall_cnt
);

    localparam int NENT = 2 ** ADDR_W;

    logic [DATA_W-1:0]      r_mem [NENT];
    logic [StallCntBus-1:0] r_stallCnt;
    logic [NREAD-1:0]       w_portStall;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NENT; e++) begin
                r_mem[e] <= '0;
            end
        end else if (we && (waddr != ADDR_W'(ZeroReg))) begin
            r_mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [DATA_W-1:0] w_rdata;

        regfile_fwd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NFWD   (NFWD)
        ) u_port (
            .i_re       (re[i]),
            .i_raddr    (raddr[i*ADDR_W +: ADDR_W]),
            .i_entry    (r_mem[raddr[i*ADDR_W +: ADDR_W]]),
            .i_we       (we),
            .i_waddr    (waddr),
            .i_wdata    (wdata),
            .i_fwd_we   (fwd_we),
            .i_fwd_addr (fwd_addr),
            .i_fwd_data (fwd_data),
            .i_fwd_rdy  (fwd_rdy),
            .o_rdata    (w_rdata),
            .o_stall    (w_portStall[i])
        );

        // Bypass sources are live during reset, so the outputs are forced quiet here.
        assign rdata[i*DATA_W +: DATA_W] = rst ? '0 : w_rdata;
    end

    assign stall_req = (|w_portStall) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (stall_req && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + StallCntBus'(1);
        end
    end

    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed and random checks of regfile_fwd in a 2/2 and a 3/3 configuration,
// both driven by one stimulus stream and compared with a rule-level model.
module tb_regfile_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  re;
    logic [14:0] raddr;
    logic [2:0]  fwd_we;
    logic [14:0] fwd_addr;
    logic [95:0] fwd_data;
    logic [2:0]  fwd_rdy;

    logic [63:0] rdataA;
    logic [95:0] rdataB;
    logic        stallA, stallB;
    logic [31:0] cntA, cntB;

    logic [31:0] mdl [32];
    logic [31:0] mCntA, mCntB;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_fwd #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NFWD(2)) dutA (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re[1:0]), .raddr(raddr[9:0]), .rdata(rdataA),
        .fwd_we(fwd_we[1:0]), .fwd_addr(fwd_addr[9:0]), .fwd_data(fwd_data[63:0]),
        .fwd_rdy(fwd_rdy[1:0]), .stall_req(stallA), .stall_cnt(cntA)
    );

    regfile_fwd #(.DATA_W(32), .ADDR_W(5), .NREAD(3), .NFWD(3)) dutB (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdataB),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_rdy(fwd_rdy), .stall_req(stallB), .stall_cnt(cntB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a read port must return under the resolution rules, and whether it must stall.
    function automatic void model(input int nfwd, input int p, output logic [31:0] d, output logic st);
        logic [4:0] ra;
        d  = '0;
        st = 1'b0;
        ra = raddr[p*5 +: 5];
        if (rst || !re[p] || ra == 5'd0) return;
        for (int k = 0; k < nfwd; k++) begin
            if (fwd_we[k] && fwd_addr[k*5 +: 5] == ra) begin
                if (fwd_rdy[k]) d = fwd_data[k*32 +: 32];
                else st = 1'b1;
                return;
            end
        end
        if (we && waddr == ra) d = wdata;
        else d = mdl[ra];
    endfunction

    function automatic logic anyStall(input int nread, input int nfwd);
        logic [31:0] d;
        logic st, any;
        any = 1'b0;
        for (int p = 0; p < nread; p++) begin
            model(nfwd, p, d, st);
            any |= st;
        end
        return any;
    endfunction

    task automatic checkAll(input string tag);
        logic [31:0] d;
        logic st;
        for (int p = 0; p < 2; p++) begin
            model(2, p, d, st);
            if (!st) checkOutput($sformatf("%s_A_rd%0d", tag, p), rdataA[p*32 +: 32], d);
        end
        for (int p = 0; p < 3; p++) begin
            model(3, p, d, st);
            if (!st) checkOutput($sformatf("%s_B_rd%0d", tag, p), rdataB[p*32 +: 32], d);
        end
        checkOutput({tag, "_A_stall"}, {31'd0, stallA}, {31'd0, anyStall(2, 2)});
        checkOutput({tag, "_B_stall"}, {31'd0, stallB}, {31'd0, anyStall(3, 3)});
        checkOutput({tag, "_A_cnt"}, cntA, mCntA);
        checkOutput({tag, "_B_cnt"}, cntB, mCntB);
    endtask

    // One rising edge: the model takes the write and counts a stall cycle if one was due.
    task automatic tick();
        logic sA, sB;
        sA = anyStall(2, 2);
        sB = anyStall(3, 3);
        @(posedge clk);
        if (!rst) begin
            if (we && waddr != 5'd0) mdl[waddr] = wdata;
            if (sA && mCntA != 32'hFFFF_FFFF) mCntA++;
            if (sB && mCntB != 32'hFFFF_FFFF) mCntB++;
        end
        #1;
    endtask

    task automatic applyStimulus(input logic iWe, input logic [4:0] iWaddr, input logic [31:0] iWdata);
        we    = iWe;
        waddr = iWaddr;
        wdata = iWdata;
    endtask

    task automatic setIdle();
        applyStimulus(1'b0, 5'd0, 32'd0);
        re       = '0;
        raddr    = '0;
        fwd_we   = '0;
        fwd_addr = '0;
        fwd_data = '0;
        fwd_rdy  = '1;
    endtask

    task automatic modelReset();
        for (int r = 0; r < 32; r++) mdl[r] = '0;
        mCntA = '0;
        mCntB = '0;
    endtask

    task automatic pulseReset(input string tag);
        rst = 1'b1;
        #1;
        modelReset();
        checkAll(tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic readAllRegs(input string tag);
        re       = '1;
        fwd_we   = '0;
        we       = 1'b0;
        for (int r = 0; r < 32; r++) begin
            raddr = {3{5'(r)}};
            #1;
            checkAll($sformatf("%s_r%0d", tag, r));
        end
    endtask

    initial begin
        rst = 1'b1;
        setIdle();
        modelReset();
        // Bypass activity during reset must not reach the outputs.
        re       = '1;
        raddr    = {5'd3, 5'd3, 5'd3};
        fwd_we   = 3'b001;
        fwd_addr = {5'd0, 5'd0, 5'd3};
        fwd_data = {32'd0, 32'd0, 32'hCAFE_0001};
        #12;
        checkAll("inReset");
        @(negedge clk);
        rst = 1'b0;
        setIdle();

        $display("[TB] write-then-read");
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0);
        re    = 3'b001;
        raddr = {10'd0, 5'd5};
        #1;
        checkOutput("wr_r5_const", rdataA[31:0], 32'hDEAD_BEEF);
        checkAll("wr_r5");
        readAllRegs("afterWr");

        $display("[TB] r0 protection");
        setIdle();
        applyStimulus(1'b1, 5'd0, 32'h1234);
        fwd_we   = 3'b001;
        fwd_addr = '0;
        fwd_data = {64'd0, 32'hFFFF_FFFF};
        re       = '1;
        raddr    = '0;
        #1;
        checkAll("r0_same");
        tick();
        setIdle();
        re = '1;
        #1;
        checkAll("r0_after");

        $display("[TB] forwarding priority");
        applyStimulus(1'b1, 5'd7, 32'h1);
        tick();
        re       = 3'b001;
        raddr    = {10'd0, 5'd7};
        fwd_we   = 3'b011;
        fwd_addr = {5'd0, 5'd7, 5'd7};
        fwd_data = {32'd0, 32'h2, 32'h3};
        fwd_rdy  = '1;
        applyStimulus(1'b1, 5'd7, 32'h4);
        #1;
        checkOutput("prio_ex", rdataA[31:0], 32'h3);
        checkAll("prio_ex");
        fwd_we = 3'b010;
        #1;
        checkOutput("prio_mem", rdataA[31:0], 32'h2);
        checkAll("prio_mem");
        fwd_we = 3'b000;
        #1;
        checkOutput("prio_wt", rdataA[31:0], 32'h4);
        checkAll("prio_wt");
        we = 1'b0;
        #1;
        checkOutput("prio_file", rdataA[31:0], 32'h1);
        checkAll("prio_file");

        $display("[TB] load-use stall");
        setIdle();
        pulseReset("rstLoad");
        fwd_we   = 3'b001;
        fwd_addr = {10'd0, 5'd9};
        fwd_data = {64'd0, 32'h0000_0055};
        fwd_rdy  = 3'b110;
        re       = 3'b010;
        raddr    = {5'd0, 5'd9, 5'd0};
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("load_stall%0d", c), {31'd0, stallA}, 32'd1);
            checkAll($sformatf("load%0d", c));
            tick();
        end
        checkOutput("load_cnt3", cntA, 32'd3);
        fwd_rdy = 3'b111;
        #1;
        checkOutput("load_rdy_stall", {31'd0, stallA}, 32'd0);
        checkOutput("load_rdy_data", rdataA[63:32], 32'h0000_0055);
        checkAll("loadRdy");

        $display("[TB] shadowed not-ready source");
        setIdle();
        fwd_we   = 3'b011;
        fwd_addr = {5'd0, 5'd4, 5'd4};
        fwd_data = {32'd0, 32'hBBBB, 32'hA};
        fwd_rdy  = 3'b101;
        re       = 3'b001;
        raddr    = {10'd0, 5'd4};
        #1;
        checkOutput("shadow_stall", {31'd0, stallA}, 32'd0);
        checkOutput("shadow_data", rdataA[31:0], 32'hA);
        checkAll("shadow");

        $display("[TB] asynchronous reset mid-stall");
        setIdle();
        applyStimulus(1'b1, 5'd12, 32'h7777_0000);
        tick();
        fwd_we   = 3'b001;
        fwd_addr = {10'd0, 5'd9};
        fwd_rdy  = 3'b110;
        re       = 3'b010;
        raddr    = {5'd0, 5'd9, 5'd0};
        applyStimulus(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        checkOutput("mid_cnt5", cntA, 32'd5);
        checkAll("midStall");
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("mid_rst_cnt", cntA, 32'd0);
        checkOutput("mid_rst_stall", {31'd0, stallA}, 32'd0);
        checkAll("midRst");
        rst = 1'b0;
        #1;
        readAllRegs("afterMidRst");

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            re       = 3'($urandom);
            raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_we   = 3'($urandom);
            fwd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data = {$urandom, $urandom, $urandom};
            for (int k = 0; k < 3; k++) fwd_rdy[k] = ($urandom_range(0, 3) != 0);
            #1;
            checkAll($sformatf("rnd%0d", n));
            tick();
        end
        setIdle();
        #1;
        checkAll("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
